bit_serial_adder_ctrl: RTL



---
 rtl/bit_serial_adder_ctrl_pkg.sv | 13 +
 rtl/bit_serial_adder_ctrl_if.sv | 37 +++
 rtl/bit_serial_adder_ctrl_fa_cell.sv | 14 +
 rtl/bit_serial_adder_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/bit_serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Optional feature macro: BSA_SIGNED_OVF_EN (adds the signed-overflow output).
package bsa_pkg;

   localparam int BSA_WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/bit_serial_adder_ctrl_if.sv
// Handshake bundle between the front end (master) and the adder controller (slave).
// Optional feature macro: BSA_SIGNED_OVF_EN (adds the ovf signal).
interface bit_serial_adder_ctrl_if #(
   parameter int WIDTH = bsa_pkg::BSA_WIDTH_DEFAULT
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
`ifdef BSA_SIGNED_OVF_EN
   logic             ovf;
`endif

   modport master (
      output in_valid, a, b, cin, out_ready,
`ifdef BSA_SIGNED_OVF_EN
      input  ovf,
`endif
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
`ifdef BSA_SIGNED_OVF_EN
      output ovf,
`endif
      output in_ready, out_valid, sum, cout, busy
   );

endinterface

// File: rtl/bit_serial_adder_ctrl_fa_cell.sv
// Single 1-bit full-adder cell, time-shared by the serial controller.
module fa_cell (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   // Plain sum/carry equations of one full-adder bit
   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands one bit per cycle,
// LSB first, through a single full-adder cell with the carry held in a flop.
// Optional feature macro: BSA_SIGNED_OVF_EN (registers the carry into the MSB
// and reports signed overflow on ovf).
module bit_serial_adder_ctrl
   import bsa_pkg::*;
#(
   parameter int WIDTH = BSA_WIDTH_DEFAULT
) (
   input logic                   clk,
   input logic                   rst_n,
   bit_serial_adder_ctrl_if.slave bus
);

   // Counter needs at least one bit even when WIDTH is 1
   localparam int CNT_W = $clog2((WIDTH < 2) ? 2 : WIDTH);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic [WIDTH-1:0] sum_next;
   logic [WIDTH-1:0] sum_q;
   logic [CNT_W-1:0] cnt;
   logic             carry_q;
   logic             cout_q;
   logic             out_valid_q;
   logic             busy_q;
   logic             fa_s;
   logic             fa_co;
   logic             last_step;
`ifdef BSA_SIGNED_OVF_EN
   logic             c_msb_in;
`endif

   fa_cell u_fa (
      .x  (a_sr[0]),
      .y  (b_sr[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   assign last_step = (cnt == CNT_W'(WIDTH - 1));

   // New sum bit enters at the MSB while the partial result moves toward the LSB
   always_comb begin
      sum_next = WIDTH'({fa_s, sum_sr} >> 1);
   end

   // Sequencer: load operands, step one bit per cycle, hold result until consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         a_sr        <= '0;
         b_sr        <= '0;
         sum_sr      <= '0;
         sum_q       <= '0;
         cnt         <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef BSA_SIGNED_OVF_EN
         c_msb_in    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_sr    <= bus.a;
                  b_sr    <= bus.b;
                  carry_q <= bus.cin;
                  cnt     <= '0;
                  sum_sr  <= '0;
                  busy_q  <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               sum_sr  <= sum_next;
               carry_q <= fa_co;
               cnt     <= cnt + 1'b1;
               if (last_step) begin
                  sum_q       <= sum_next;
                  cout_q      <= fa_co;
                  out_valid_q <= 1'b1;
`ifdef BSA_SIGNED_OVF_EN
                  c_msb_in    <= carry_q;
`endif
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
`ifdef BSA_SIGNED_OVF_EN
   assign bus.ovf       = c_msb_in ^ cout_q;
`endif

endmodule
